freq_gate_ctrl: RTL and testbench

Measurement sequencer in the measured-clock domain (clk_fx) of the frequency counter. It generates the gate window with a programmable length and guard bands, and counts clk_fx cycles inside the gate. It then hands the result to the reference-clock (clk_fs) side with a four-phase req/ack handshake and re-arms for one-shot or continuous operation.

---
 rtl/freq_meas_pkg.sv | 19 +
 rtl/freq_gate_ctrl_if.sv | 30 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/freq_gate_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency counter: sequencer states and default widths.
// Used by both the clk_fx sequencer and the clk_fs-side counter.
package freq_meas_pkg;

  localparam int CNT_W_DEF   = 30;
  localparam int LEN_W_DEF   = 16;
  localparam int GUARD_W_DEF = 8;
  localparam int unsigned TIMEOUT_DEF = 65535;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    GATE = 3'd2,
    POST = 3'd3,
    REQ  = 3'd4,
    REL  = 3'd5
  } meas_state_e;

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Control/result bundle between the gate sequencer and its host / clk_fs side.
interface freq_gate_ctrl_if #(
  parameter int CNT_W   = freq_meas_pkg::CNT_W_DEF,
  parameter int LEN_W   = freq_meas_pkg::LEN_W_DEF,
  parameter int GUARD_W = freq_meas_pkg::GUARD_W_DEF
) ();

  logic               start;
  logic               cont_en;
  logic [LEN_W-1:0]   gate_len;
  logic [GUARD_W-1:0] guard_len;
  logic               meas_ack;
  logic               gate;
  logic               meas_req;
  logic [CNT_W-1:0]   fx_cnt;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, cont_en, gate_len, guard_len, meas_ack,
    input  gate, meas_req, fx_cnt, busy, done, err
  );

  modport slave (
    input  start, cont_en, gate_len, guard_len, meas_ack,
    output gate, meas_req, fx_cnt, busy, done, err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with async reset to 0; also reused for gate on the clk_fs side.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-window sequencer in the clk_fx domain with req/ack result hand-off.
// Optional GATE_TIMEOUT_EN adds an ack-wait timeout with a sticky err flag.
//
// state | meaning
// IDLE  | waiting for start or cont_en
// PRE   | leading guard band, gate low
// GATE  | gate high, counting clk_fx
// POST  | trailing guard band (min 1 cycle), fx_cnt loaded on entry
// REQ   | meas_req high, waiting for ack_s high
// REL   | meas_req low, waiting for ack_s low, then done
module freq_gate_ctrl
  import freq_meas_pkg::*;
#(
`ifdef GATE_TIMEOUT_EN
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
`endif
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF
) (
  input  logic            clk_fx,
  input  logic            rst_n,
  freq_gate_ctrl_if.slave bus
);

  localparam int TMR_W = (LEN_W > GUARD_W) ? LEN_W : GUARD_W;

  meas_state_e        state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, len_in;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   gcnt_q, gcnt_d;
  logic [CNT_W-1:0]   fx_cnt_q, fx_cnt_d;
  logic               gate_q, req_q, busy_q, done_q, done_d;
  logic               ack_s;
  logic               arm;

`ifdef GATE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`endif

  sync_2ff #(.W(1)) u_ack_sync (
    .clk   (clk_fx),
    .rst_n (rst_n),
    .d_i   (bus.meas_ack),
    .q_o   (ack_s)
  );

  assign len_in = (bus.gate_len == '0) ? LEN_W'(1) : bus.gate_len;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    guard_d  = guard_q;
    tmr_d    = tmr_q;
    gcnt_d   = gcnt_q;
    fx_cnt_d = fx_cnt_q;
    done_d   = 1'b0;
    arm      = 1'b0;
`ifdef GATE_TIMEOUT_EN
    to_d     = to_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef GATE_TIMEOUT_EN
        if (bus.start) err_d = 1'b0;
        arm = bus.start || (bus.cont_en && !err_q);
`else
        arm = bus.start || bus.cont_en;
`endif
      end
      PRE: begin
        if (tmr_q == '0) begin
          state_d = GATE;
          tmr_d   = TMR_W'(len_q) - TMR_W'(1);
          gcnt_d  = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      GATE: begin
        gcnt_d = gcnt_q + CNT_W'(1);
        if (tmr_q == '0) begin
          state_d  = POST;
          fx_cnt_d = gcnt_q + CNT_W'(1);
          tmr_d    = (guard_q == '0) ? '0 : TMR_W'(guard_q) - TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      POST: begin
        if (tmr_q == '0) begin
          state_d = REQ;
`ifdef GATE_TIMEOUT_EN
          to_d = TO_LOAD;
`endif
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = REL;
`ifdef GATE_TIMEOUT_EN
          to_d = TO_LOAD;
        end else if (to_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q - TO_W'(1);
`endif
        end
      end
      REL: begin
        if (!ack_s) begin
          done_d = 1'b1;
          if (bus.cont_en) arm = 1'b1;
          else             state_d = IDLE;
`ifdef GATE_TIMEOUT_EN
        end else if (to_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q - TO_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Arming (from IDLE or continuous re-arm) snapshots the configuration.
    if (arm) begin
      len_d   = len_in;
      guard_d = bus.guard_len;
      if (bus.guard_len == '0) begin
        state_d = GATE;
        tmr_d   = TMR_W'(len_in) - TMR_W'(1);
        gcnt_d  = '0;
      end else begin
        state_d = PRE;
        tmr_d   = TMR_W'(bus.guard_len) - TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      guard_q  <= '0;
      tmr_q    <= '0;
      gcnt_q   <= '0;
      fx_cnt_q <= '0;
      gate_q   <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      guard_q  <= guard_d;
      tmr_q    <= tmr_d;
      gcnt_q   <= gcnt_d;
      fx_cnt_q <= fx_cnt_d;
      gate_q   <= (state_d == GATE);
      req_q    <= (state_d == REQ);
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
    end
  end

`ifdef GATE_TIMEOUT_EN
  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gate     = gate_q;
  assign bus.meas_req = req_q;
  assign bus.fx_cnt   = fx_cnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: expected windows queued at stimulus, checked as the DUT runs them.
module tb_freq_gate_ctrl;
  import freq_meas_pkg::*;

  localparam int LIMIT = 5000;

  typedef struct {
    int len;
    int guard;
  } exp_t;

  logic clk_fx;
  logic rst_n;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  freq_gate_ctrl_if bus ();

`ifdef GATE_TIMEOUT_EN
  freq_gate_ctrl #(.TIMEOUT(64)) dut (
    .clk_fx (clk_fx),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );
`else
  freq_gate_ctrl dut (
    .clk_fx (clk_fx),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );
`endif

  initial clk_fx = 1'b0;
  always #5 clk_fx = ~clk_fx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fx);
    #1;
  endtask

  // Follows one window from just after its arming edge to the done pulse.
  // ack_dly < 0 leaves the request unanswered and returns once meas_req is seen.
  task automatic run_window(input string tag, input int ack_dly, input bit inject,
                            input int new_len, input bit cont_next);
    exp_t e;
    int   cnt;
    cnt = 0;
    while (!bus.gate && cnt < LIMIT) begin tick(); cnt++; end
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, ":pre"}, 64'(cnt), 64'(e.guard));
    cnt = 0;
    while (bus.gate && cnt < LIMIT) begin
      cnt++;
      if (cnt == 3 && new_len >= 0) bus.gate_len = 16'(new_len);
      if (inject) bus.start = (cnt == 3);
      tick();
    end
    bus.start = 1'b0;
    check({tag, ":gate_len"}, 64'(cnt), 64'(e.len));
    cnt = 0;
    while (!bus.meas_req && cnt < LIMIT) begin tick(); cnt++; end
    check({tag, ":post"}, 64'(cnt), 64'((e.guard == 0) ? 1 : e.guard));
    check({tag, ":fx_cnt"}, 64'(bus.fx_cnt), 64'(e.len));
    if (inject) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    if (ack_dly < 0) return;
    repeat (ack_dly) tick();
    bus.meas_ack = 1'b1;
    cnt = 0;
    while (bus.meas_req && cnt < LIMIT) begin tick(); cnt++; end
    check({tag, ":ack_lat"}, 64'(cnt), 64'd3);
    check({tag, ":fx_hold"}, 64'(bus.fx_cnt), 64'(e.len));
    bus.cont_en = cont_next;
    repeat (5) tick();
    bus.meas_ack = 1'b0;
    cnt = 0;
    while (!bus.done && cnt < LIMIT) begin tick(); cnt++; end
    check({tag, ":done_lat"}, 64'(cnt), 64'd3);
    check({tag, ":busy_after"}, 64'(bus.busy), 64'(cont_next));
    if (!cont_next) begin
      tick();
      check({tag, ":done_single"}, 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int g;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cont_en   = 1'b0;
    bus.gate_len  = '0;
    bus.guard_len = '0;
    bus.meas_ack  = 1'b0;
    repeat (3) tick();
    check("rst:gate", 64'(bus.gate), 64'd0);
    check("rst:req", 64'(bus.meas_req), 64'd0);
    check("rst:fx_cnt", 64'(bus.fx_cnt), 64'd0);
    check("rst:busy", 64'(bus.busy), 64'd0);
    check("rst:done", 64'(bus.done), 64'd0);
    check("rst:err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // One-shot, long gate with guard bands
    bus.gate_len  = 16'd2000;
    bus.guard_len = 8'd10;
    sb.push_back('{len: 2000, guard: 10});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_window("oneshot", 5, 1'b0, -1, 1'b0);

    // Boundary: zero length and zero guard
    bus.gate_len  = 16'd0;
    bus.guard_len = 8'd0;
    sb.push_back('{len: 1, guard: 0});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_window("zero_cfg", 2, 1'b0, -1, 1'b0);

    // start pulses during GATE and REQ must be ignored
    bus.gate_len  = 16'd30;
    bus.guard_len = 8'd2;
    sb.push_back('{len: 30, guard: 2});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_window("inject", 4, 1'b1, -1, 1'b0);
    g = 0;
    repeat (20) begin tick(); g += int'(bus.gate) + int'(bus.busy); end
    check("inject:no_extra", 64'(g), 64'd0);

    // Continuous: four windows at 100, length change during the fourth, last at 50
    bus.gate_len  = 16'd100;
    bus.guard_len = 8'd4;
    sb.push_back('{len: 100, guard: 4});
    sb.push_back('{len: 100, guard: 4});
    sb.push_back('{len: 100, guard: 4});
    sb.push_back('{len: 100, guard: 4});
    sb.push_back('{len: 50,  guard: 4});
    bus.cont_en = 1'b1;
    tick();
    run_window("cont1", 5, 1'b0, -1, 1'b1);
    run_window("cont2", 3, 1'b0, -1, 1'b1);
    run_window("cont3", 7, 1'b0, -1, 1'b1);
    run_window("cont4", 5, 1'b0, 50, 1'b1);
    run_window("cont5", 5, 1'b0, -1, 1'b0);
    check("cont:sb_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a gate
    bus.gate_len  = 16'd200;
    bus.guard_len = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    g = 0;
    while (!bus.gate && g < LIMIT) begin tick(); g++; end
    check("midrst:gate_seen", 64'(bus.gate), 64'd1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst:gate", 64'(bus.gate), 64'd0);
    check("midrst:req", 64'(bus.meas_req), 64'd0);
    check("midrst:busy", 64'(bus.busy), 64'd0);
    check("midrst:done", 64'(bus.done), 64'd0);
    check("midrst:fx_cnt", 64'(bus.fx_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    g = 0;
    repeat (5) begin tick(); g += int'(bus.busy) + int'(bus.gate); end
    check("midrst:idle_after", 64'(g), 64'd0);

`ifdef GATE_TIMEOUT_EN
    // No ack: timeout after 64 cycles in REQ
    bus.gate_len  = 16'd5;
    bus.guard_len = 8'd2;
    sb.push_back('{len: 5, guard: 2});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_window("tmo", -1, 1'b0, -1, 1'b0);
    g = 0;
    begin
      int dn;
      dn = 0;
      while (bus.meas_req && g < LIMIT) begin
        g++;
        dn += int'(bus.done);
        tick();
      end
      check("tmo:req_cycles", 64'(g), 64'd64);
      check("tmo:err", 64'(bus.err), 64'd1);
      check("tmo:busy", 64'(bus.busy), 64'd0);
      bus.cont_en = 1'b1;
      repeat (10) begin tick(); dn += int'(bus.done) + int'(bus.busy); end
      bus.cont_en = 1'b0;
      check("tmo:no_done_no_rearm", 64'(dn), 64'd0);
      check("tmo:err_sticky", 64'(bus.err), 64'd1);
    end
    sb.push_back('{len: 5, guard: 2});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("tmo:err_cleared", 64'(bus.err), 64'd0);
    run_window("after_tmo", 3, 1'b0, -1, 1'b0);
`else
    check("noto:err_tied", 64'(bus.err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
